// File: rtl/snn_osc_network.sv
// Spiking oscillator network: N leaky integrate-and-fire neurons with an all-to-all
// signed weight matrix, per-neuron bias, refractory hold and a saturating spike counter.
module snn_osc_network #(
    parameter int N_NEURONS  = 4,
    parameter int V_WIDTH    = 8,
    parameter int W_WIDTH    = 4,
    parameter int LEAK_SHIFT = 3,
    parameter int REFRAC     = 2,
    parameter int CNT_WIDTH  = 16,
    localparam int ADDR_W    = $clog2(N_NEURONS*N_NEURONS+N_NEURONS)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ena,
    input  logic                 cfg_we,
    input  logic [ADDR_W-1:0]    cfg_addr,
    input  logic [V_WIDTH-1:0]   cfg_data,
    input  logic [V_WIDTH-1:0]   threshold,
    input  logic                 cnt_clr,
    output logic [N_NEURONS-1:0] spike_out,
    output logic                 spike_any,
    output logic [CNT_WIDTH-1:0] spike_count
);
    localparam int N_SYN = N_NEURONS * N_NEURONS;
    // Wide enough for v + bias plus N worst-case weights without wrapping.
    localparam int ACC_W = V_WIDTH + W_WIDTH + 4;
    localparam int RF_W  = (REFRAC > 0) ? $clog2(REFRAC + 1) : 1;
    localparam int POP_W = $clog2(N_NEURONS + 1);
    localparam logic signed [ACC_W-1:0] V_MAX = ACC_W'({V_WIDTH{1'b1}});

    logic signed [W_WIDTH-1:0]     r_w      [N_SYN];
    logic [V_WIDTH-1:0]            r_bias   [N_NEURONS];
    logic [V_WIDTH-1:0]            r_v      [N_NEURONS];
    logic [RF_W-1:0]               r_refrac [N_NEURONS];
    logic [N_NEURONS-1:0]          r_spike;
    logic [CNT_WIDTH-1:0]          r_cnt;

    logic [N_NEURONS*V_WIDTH-1:0]  w_vc;
    logic [N_NEURONS-1:0]          w_fire;
    logic [N_NEURONS-1:0]          w_spike_next;
    logic [POP_W-1:0]              w_pop;
    logic [CNT_WIDTH:0]            w_cnt_sum;

    genvar gi;
    generate
        for (gi = 0; gi < N_NEURONS; gi++) begin : g_neuron
            logic signed [ACC_W-1:0] w_acc;
            logic [V_WIDTH-1:0]      w_clamp;

            always_comb begin
                w_acc = ACC_W'(r_v[gi]) - ACC_W'(r_v[gi] >> LEAK_SHIFT) + ACC_W'(r_bias[gi]);
                for (int j = 0; j < N_NEURONS; j++) begin
                    if (r_spike[j]) begin
                        w_acc = w_acc + ACC_W'(r_w[gi*N_NEURONS + j]);
                    end
                end
            end

            always_comb begin
                if (w_acc[ACC_W-1]) begin
                    w_clamp = '0;
                end else if (w_acc > V_MAX) begin
                    w_clamp = '1;
                end else begin
                    w_clamp = w_acc[V_WIDTH-1:0];
                end
            end

            assign w_vc[gi*V_WIDTH +: V_WIDTH] = w_clamp;
            assign w_fire[gi] = (r_refrac[gi] == '0) && (w_clamp >= threshold);
        end
    endgenerate

    assign w_spike_next = ena ? w_fire : '0;

    always_comb begin
        w_pop = '0;
        for (int i = 0; i < N_NEURONS; i++) begin
            w_pop = w_pop + POP_W'(w_spike_next[i]);
        end
        w_cnt_sum = {1'b0, r_cnt} + (CNT_WIDTH+1)'(w_pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_spike <= '0;
            for (int i = 0; i < N_NEURONS; i++) begin
                r_v[i]      <= '0;
                r_refrac[i] <= '0;
            end
        end else begin
            r_spike <= w_spike_next;
            if (ena) begin
                for (int i = 0; i < N_NEURONS; i++) begin
                    if (r_refrac[i] != '0) begin
                        r_refrac[i] <= r_refrac[i] - RF_W'(1);
                        r_v[i]      <= '0;
                    end else if (w_fire[i]) begin
                        r_refrac[i] <= RF_W'(REFRAC);
                        r_v[i]      <= '0;
                    end else begin
                        r_v[i]      <= w_vc[i*V_WIDTH +: V_WIDTH];
                    end
                end
            end
        end
    end

    // Config writes land after this edge's update, so the update sees old values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < N_SYN; k++) begin
                r_w[k] <= '0;
            end
            for (int k = 0; k < N_NEURONS; k++) begin
                r_bias[k] <= '0;
            end
        end else if (cfg_we) begin
            for (int k = 0; k < N_SYN; k++) begin
                if (cfg_addr == ADDR_W'(k)) begin
                    r_w[k] <= cfg_data[W_WIDTH-1:0];
                end
            end
            for (int k = 0; k < N_NEURONS; k++) begin
                if (cfg_addr == ADDR_W'(N_SYN + k)) begin
                    r_bias[k] <= cfg_data;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (cnt_clr) begin
            r_cnt <= '0;
        end else if (w_cnt_sum[CNT_WIDTH]) begin
            r_cnt <= '1;
        end else begin
            r_cnt <= w_cnt_sum[CNT_WIDTH-1:0];
        end
    end

    assign spike_out   = r_spike;
    assign spike_any   = |r_spike;
    assign spike_count = r_cnt;

endmodule
